// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the register-file dump reader.
// Imported by every block that needs the RF geometry.
package regfile_pkg;

    localparam int NumRegisters = 32;
    localparam int AddrWidth    = 6;
    localparam int DataWidth    = 64;

    localparam logic [AddrWidth-1:0] ZeroReg = '0;
    localparam logic [AddrWidth-1:0] NumRegsIdx = AddrWidth'(NumRegisters);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSend   = 2'd1,
        StFinish = 2'd2
    } reader_state_e;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks a register range through one RF read port and streams (index, data)
// beats on a valid/ready interface while folding them into an XOR checksum.
module regfile_dump_reader
    import regfile_pkg::*;
(
    input  logic                 Clock,
    input  logic                 ResetN,
    input  logic                 Start,
    input  logic [AddrWidth-1:0] FirstRegister,
    input  logic [AddrWidth-1:0] LastRegister,
    input  logic                 Abort,
    output logic [AddrWidth-1:0] ReadRegister,
    input  logic [DataWidth-1:0] ReadData,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [AddrWidth-1:0] OutRegister,
    output logic [DataWidth-1:0] OutData,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Error,
    output logic [DataWidth-1:0] Checksum
);

    reader_state_e        state_q, state_d;
    logic [AddrWidth-1:0] ptr_q, ptr_d;
    logic [AddrWidth-1:0] last_q, last_d;
    logic [AddrWidth-1:0] out_reg_q, out_reg_d;
    logic [DataWidth-1:0] out_data_q, out_data_d;
    logic [DataWidth-1:0] checksum_q, checksum_d;
    logic                 err_q, err_d;
    logic                 range_ok;
    logic                 fire;

    assign range_ok = (FirstRegister <= LastRegister)
                    && (LastRegister < NumRegsIdx);
    assign fire     = (state_q == StSend) && OutReady;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        last_d       = last_q;
        out_reg_d    = out_reg_q;
        out_data_d   = out_data_q;
        checksum_d   = checksum_q;
        err_d        = err_q;
        ReadRegister = ptr_q;
        unique case (state_q)
            StIdle: begin
                ReadRegister = FirstRegister;
                if (Start) begin
                    checksum_d = '0;
                    if (range_ok) begin
                        out_data_d = ReadData;
                        out_reg_d  = FirstRegister;
                        ptr_d      = FirstRegister + AddrWidth'(1);
                        last_d     = LastRegister;
                        err_d      = 1'b0;
                        state_d    = StSend;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StFinish;
                    end
                end
            end
            StSend: begin
                if (fire) begin
                    checksum_d = checksum_q ^ out_data_q;
                end
                // Abort wins over advancing; an accepted beat is still folded in
                if (Abort) begin
                    state_d = StIdle;
                end else if (fire) begin
                    if (out_reg_q == last_q) begin
                        state_d = StFinish;
                    end else begin
                        out_data_d = ReadData;
                        out_reg_d  = ptr_q;
                        ptr_d      = ptr_q + AddrWidth'(1);
                    end
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q    <= StIdle;
            ptr_q      <= ZeroReg;
            last_q     <= ZeroReg;
            out_reg_q  <= ZeroReg;
            out_data_q <= '0;
            checksum_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            last_q     <= last_d;
            out_reg_q  <= out_reg_d;
            out_data_q <= out_data_d;
            checksum_q <= checksum_d;
            err_q      <= err_d;
        end
    end

    assign OutValid    = (state_q == StSend);
    assign Busy        = (state_q == StSend);
    assign Done        = (state_q == StFinish);
    assign Error       = (state_q == StFinish) && err_q;
    assign OutRegister = out_reg_q;
    assign OutData     = out_data_q;
    assign Checksum    = checksum_q;

endmodule
